alu_sequencer: RTL

Multi-cycle controller that sequences the CPU's four-operation ALU (add, subtract, multiply, divide) using the same 2-bit opcode encoding as the decoder. It accepts one operation at a time over a valid/ready handshake and runs add/sub in one cycle. Multiply is iterative shift-add and divide is restoring, one iteration per cycle. The result is held on a valid/ready output until it is consumed. It sits between instruction issue and writeback.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter_core.sv | 31 +++
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, one-hot controls and state encoding for the ALU sequencer
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [3:0] CTL_ADD = 4'b0001;
  localparam logic [3:0] CTL_SUB = 4'b0010;
  localparam logic [3:0] CTL_MUL = 4'b0100;
  localparam logic [3:0] CTL_DIV = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic [3:0] op_onehot(input logic [1:0] op);
    case (op)
      OP_ADD:  return CTL_ADD;
      OP_SUB:  return CTL_SUB;
      OP_MUL:  return CTL_MUL;
      default: return CTL_DIV;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_core.sv
// rtl/alu_iter_core.sv - one combinational shift-add multiply or restoring-divide step
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic [1:0]         op_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] hi_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // acc holds {high, low}: product/multiplier for mul, remainder/quotient for div
  always_comb begin
    hi_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    trial  = rem_sh - {1'b0, operand_i};
    if (op_i == OP_MUL) begin
      acc_o = {hi_sum, acc_i[WIDTH-1:1]};
    end else if (trial[WIDTH]) begin
      acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle add/sub/mul/div sequencer with valid/ready handshakes
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero,
  output logic [3:0]         active_op
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [1:0]           op_q, op_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 dz_q, dz_d;
  logic [3:0]           active_q, active_d;

  logic [2*WIDTH-1:0]   core_acc, core_out;
  logic [WIDTH-1:0]     core_opnd;
  logic [1:0]           core_op;
  logic [WIDTH:0]       sum_w, diff_w;

  // The accept edge performs the first iteration straight from the operands,
  // so EXEC lasts WIDTH-1 cycles and mul/div results appear WIDTH cycles after accept.
  assign core_acc  = (state_q == IDLE) ? {{WIDTH{1'b0}}, a} : acc_q;
  assign core_opnd = (state_q == IDLE) ? b : opnd_q;
  assign core_op   = (state_q == IDLE) ? opcode : op_q;

  alu_iter_core #(.WIDTH(WIDTH)) u_core (
    .acc_i     (core_acc),
    .operand_i (core_opnd),
    .op_i      (core_op),
    .acc_o     (core_out)
  );

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d     = opcode;
          opnd_d   = b;
          cnt_d    = '0;
          dz_d     = 1'b0;
          active_d = op_onehot(opcode);
          case (opcode)
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum_w};
              state_d  = DONE;
            end
            OP_SUB: begin
              result_d = {{(WIDTH-1){1'b0}}, diff_w};
              state_d  = DONE;
            end
            OP_MUL: begin
              acc_d   = core_out;
              state_d = EXEC;
            end
            default: begin
              if (b == '0) begin
                result_d = {a, {WIDTH{1'b1}}};
                dz_d     = 1'b1;
                state_d  = DONE;
              end else begin
                acc_d   = core_out;
                state_d = EXEC;
              end
            end
          endcase
        end
      end
      EXEC: begin
        acc_d = core_out;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 2)) begin
          result_d = core_out;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          active_d = 4'b0000;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      opnd_q   <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
      active_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      active_q <= active_d;
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign result    = result_q;
  assign div_zero  = dz_q;
  assign active_op = active_q;

endmodule
